// File: rtl/serial_result_select_if.sv
// Handshake/data bundle between the serial execution units, serial_result_select and its consumer.
// The master side drives start/function/serial bits/ack; the slave side is the selector.
`timescale 1ns/1ps
interface serial_result_select_if #(
  parameter int NUM_CH    = 5,
  parameter int SEL_WIDTH = 3,
  parameter int WIDTH     = 8
);
  logic                 start_i;
  logic [SEL_WIDTH-1:0] f_i;
  logic [NUM_CH-1:0]    results_i;
  logic                 ack_i;
  logic                 sel_bit_o;
  logic                 busy_o;
  logic [WIDTH-1:0]     result_o;
  logic                 valid_o;
  logic                 zero_o;
  logic                 bad_f_o;

  modport master (
    output start_i, f_i, results_i, ack_i,
    input  sel_bit_o, busy_o, result_o, valid_o, zero_o, bad_f_o
  );

  modport slave (
    input  start_i, f_i, results_i, ack_i,
    output sel_bit_o, busy_o, result_o, valid_o, zero_o, bad_f_o
  );
endinterface

// File: rtl/serial_result_select.sv
// Registered serial result selector: picks one 1-bit channel, collects WIDTH bits LSB-first.
// Optional all-zero flag is built when SERIAL_RESULT_ZERO_FLAG_EN is defined.
`timescale 1ns/1ps
module serial_result_select #(
  parameter int NUM_CH     = 5,
  parameter int SEL_WIDTH  = 3,
  parameter int WIDTH      = 8,
  parameter int DEFAULT_CH = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  serial_result_select_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [SEL_WIDTH-1:0] DEF_SEL  = SEL_WIDTH'(DEFAULT_CH);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_shift;
  logic                 r_bad;
  logic                 w_accept;
  logic                 w_f_ok;
  logic                 w_sel_bit;

  assign w_f_ok    = (int'(bus.f_i) < NUM_CH);
  assign w_sel_bit = bus.results_i[r_sel];

  // A start is only taken in IDLE, or in DONE when it arrives together with ack.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) w_state_next = DONE;
      end
      DONE: begin
        if (bus.ack_i) begin
          if (bus.start_i) begin
            w_accept     = 1'b1;
            w_state_next = RUN;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sel   <= DEF_SEL;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_sel   <= w_f_ok ? bus.f_i : DEF_SEL;
        r_bad   <= ~w_f_ok;
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (r_state == RUN) begin
        // New bit enters at the MSB so the first capture ends up in bit 0.
        r_shift <= {w_sel_bit, r_shift[WIDTH-1:1]};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_RESULT_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_zero <= 1'b1;
    end else if (r_state == RUN && w_sel_bit) begin
      r_zero <= 1'b0;
    end
  end

  assign bus.zero_o = (r_state == DONE) & r_zero;
`else
  assign bus.zero_o = 1'b0;
`endif

  assign bus.sel_bit_o = w_sel_bit;
  assign bus.busy_o    = (r_state == RUN);
  assign bus.valid_o   = (r_state == DONE);
  assign bus.result_o  = r_shift;
  assign bus.bad_f_o   = r_bad;
endmodule

// File: tb/tb_serial_result_select.sv
// Scoreboard bench for serial_result_select: stimulus queues expected results,
// a negedge monitor compares them when valid_o rises.
`timescale 1ns/1ps
module tb_serial_result_select;
  localparam int NUM_CH    = 5;
  localparam int SEL_WIDTH = 3;
  localparam int WIDTH     = 8;

`ifdef SERIAL_RESULT_ZERO_FLAG_EN
  localparam logic ZERO_ON = 1'b1;
`else
  localparam logic ZERO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_result_select_if #(.NUM_CH(NUM_CH), .SEL_WIDTH(SEL_WIDTH), .WIDTH(WIDTH)) bus ();

  serial_result_select #(
    .NUM_CH(NUM_CH), .SEL_WIDTH(SEL_WIDTH), .WIDTH(WIDTH), .DEFAULT_CH(0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] res;
    logic       bad;
    logic       zero;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per rising valid_o.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_o && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result 0x%0h at cycle %0d, expected no result",
                   bus.result_o, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("txn: result=0x%0h bad_f=%0b zero=%0b cycle=%0d (expect 0x%0h %0b %0b %0d)",
                   bus.result_o, bus.bad_f_o, bus.zero_o, cyc, e.res, e.bad, e.zero, e.cyc);
          chk("sb_result", 32'(bus.result_o), 32'(e.res));
          chk("sb_bad_f",  32'(bus.bad_f_o),  32'(e.bad));
          chk("sb_zero",   32'(bus.zero_o),   32'(e.zero));
          chk("sb_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_valid = bus.valid_o;
    end
  end

  // Called right after a negedge; returns right after the negedge following the last capture.
  task automatic run_op(input logic [2:0] f, input logic [4:0][7:0] bits, input logic with_ack,
                        input logic [7:0] exp_res, input logic exp_bad, input logic exp_zero,
                        input int midrun);
    bus.start_i = 1'b1;
    bus.f_i     = f;
    bus.ack_i   = with_ack;
    @(negedge clk);
    chk("start_busy",  32'(bus.busy_o),  32'd1);
    chk("start_valid", 32'(bus.valid_o), 32'd0);
    q.push_back('{exp_res, exp_bad, exp_zero, cyc + WIDTH});
    bus.ack_i = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == midrun) begin
        bus.start_i = 1'b1;
        bus.f_i     = 3'd2;
      end else begin
        bus.start_i = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) bus.results_i[c] = bits[c][k];
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk("done_valid", 32'(bus.valid_o), 32'd1);
    chk("done_busy",  32'(bus.busy_o),  32'd0);
  endtask

  task automatic ack_done();
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("ack_valid", 32'(bus.valid_o), 32'd0);
    chk("ack_busy",  32'(bus.busy_o),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.f_i       = '0;
    bus.results_i = '0;
    bus.ack_i     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(bus.busy_o),   32'd0);
    chk("rst_valid",  32'(bus.valid_o),  32'd0);
    chk("rst_result", 32'(bus.result_o), 32'd0);
    chk("rst_bad_f",  32'(bus.bad_f_o),  32'd0);
    chk("rst_zero",   32'(bus.zero_o),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal: channel 3 = 1,0,1,1,0,0,1,0 -> 8'h4D, others complement.
    run_op(3'd3, {8'hB2, 8'h4D, 8'hB2, 8'hB2, 8'hB2}, 1'b0, 8'h4D, 1'b0, 1'b0, -1);

    // Hold DONE for 20 cycles with a stray start (no ack).
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.start_i = 1'b1;
        bus.f_i     = 3'd4;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      chk("hold_result", 32'(bus.result_o), 32'h4D);
      chk("hold_valid",  32'(bus.valid_o),  32'd1);
    end
    bus.start_i = 1'b0;

    // Channel 3 is still selected in DONE.
    bus.results_i = 5'b01000;
    #1 chk("sel_bit_ch3_hi", 32'(bus.sel_bit_o), 32'd1);
    bus.results_i = 5'b10111;
    #1 chk("sel_bit_ch3_lo", 32'(bus.sel_bit_o), 32'd0);
    @(negedge clk);

    // Back-to-back ack+start with f=0: channel 0 = 8'h81.
    run_op(3'd0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h81}, 1'b1, 8'h81, 1'b0, 1'b0, -1);
    ack_done();

    // Ack in IDLE changes nothing.
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("idle_ack_result", 32'(bus.result_o), 32'h81);
    chk("idle_ack_valid",  32'(bus.valid_o),  32'd0);
    chk("idle_ack_busy",   32'(bus.busy_o),   32'd0);
    chk("idle_ack_bad_f",  32'(bus.bad_f_o),  32'd0);
    @(negedge clk);
    chk("idle_ack_busy2",  32'(bus.busy_o),   32'd0);

    // Invalid code 6 falls back to channel 0 (all zero); channel 4 all ones.
    run_op(3'd6, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}, 1'b0, 8'h00, 1'b1, ZERO_ON, -1);
    ack_done();
    chk("bad_f_held", 32'(bus.bad_f_o), 32'd1);
    bus.results_i = 5'b00001;
    #1 chk("sel_bit_default", 32'(bus.sel_bit_o), 32'd1);
    @(negedge clk);

    // Mid-run start with f=2 at bit 3 must be ignored.
    run_op(3'd1, {8'h00, 8'h00, 8'h3C, 8'hA5, 8'h00}, 1'b0, 8'hA5, 1'b0, 1'b0, 3);
    chk("midrun_bad_f", 32'(bus.bad_f_o), 32'd0);
    ack_done();

    // Reset during bit 4 aborts the operation without a result.
    bus.start_i = 1'b1;
    bus.f_i     = 3'd1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.results_i = 5'b00010;
      @(negedge clk);
    end
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",   32'(bus.busy_o),   32'd0);
    chk("midrst_valid",  32'(bus.valid_o),  32'd0);
    chk("midrst_result", 32'(bus.result_o), 32'd0);
    chk("midrst_bad_f",  32'(bus.bad_f_o),  32'd0);
    chk("midrst_zero",   32'(bus.zero_o),   32'd0);
    bus.results_i = 5'b00001;
    #1 chk("midrst_sel_bit", 32'(bus.sel_bit_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    chk("midrst_no_valid", 32'(bus.valid_o), 32'd0);

    // Normal completion after the abort.
    run_op(3'd2, {8'h00, 8'h00, 8'h5A, 8'h00, 8'h00}, 1'b0, 8'h5A, 1'b0, 1'b0, -1);
    ack_done();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_result_select.md
# serial_result_select

Parametrised, registered successor to the ALU result multiplexer. Selects one of `NUM_CH` 1-bit serial unit outputs (AND, OR, XOR, adder, subtractor, …) by a function code latched at operation start. Collects `WIDTH` result bits LSB-first into a parallel result register and presents it with a valid/ack handshake. Sits between the bit-serial execution units and the output/register stage.

## Interface
- `NUM_CH`, 5: number of 1-bit result channels.
- `SEL_WIDTH`, 3: width of function code; must satisfy 2^SEL_WIDTH ≥ NUM_CH.
- `WIDTH`, 8: bits per operation (≥2).
- `DEFAULT_CH`, 0: channel used when the function code is out of range.

Ports:
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  start request; accepted per the handshake rules below.
- `f_i`  in  SEL_WIDTH  function code, sampled only on accepted start.
- `results_i`  in  NUM_CH  current serial bit of each unit; bit k = channel k.
- `ack_i`  in  1  consumer accepts the result.
- `sel_bit_o`  out  1  combinational `results_i[sel_q]`, for downstream serial use.
- `busy_o`  out  1  high in RUN.
- `result_o`  out  WIDTH  collected result; bit 0 = first captured bit.
- `valid_o`  out  1  high in DONE.
- `zero_o`  out  1  result is all-zero (see Configuration).
- `bad_f_o`  out  1  latched f_i was ≥ NUM_CH.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE, `sel_q`=DEFAULT_CH, counter 0, all outputs 0.
- IDLE, `start_i`=1:
  - latch `sel_q` = f_i if f_i < NUM_CH, else DEFAULT_CH and set `bad_f_o`=1 (else 0);
  - clear shift register and counter; → RUN.
- RUN: each edge shifts `results_i[sel_q]` into the MSB of the shift register, shifting right, and increments the counter.
  - On the WIDTH-th capture → DONE.
  - `start_i` and `f_i` are ignored in RUN.
- DONE: `result_o` = shift register, held stable.
  - `ack_i`=1 without `start_i` → IDLE, `valid_o`=0.
  - `ack_i`=1 with `start_i`=1 → accepted back-to-back start: latch new code and → RUN.
  - `start_i` without `ack_i` is ignored.
  - `ack_i` outside DONE has no effect.
- `result_o` and `bad_f_o` hold their last values until the next accepted start. `result_o` is cleared at start.
- Counter width is clog2(WIDTH+1). It wraps only via state change, never by overflow.
- `rst_i` has priority over every event, in any state. It returns the block to reset values on the next edge and aborts any in-flight operation without producing `valid_o`.

## Timing
- Start is accepted at edge T. Bit k is sampled at edge T+1+k, for k = 0..WIDTH-1.
- `busy_o`=1 after edge T and through edge T+WIDTH-1.
- `valid_o`=1 after edge T+WIDTH. Latency from start to valid is WIDTH+1 edges, including the start edge.
- Back-to-back: with ack+start at edge A, `valid_o`=0 and `busy_o`=1 after A, and the next valid follows after A+WIDTH. Throughput is one result per WIDTH+1 cycles.
- `sel_bit_o` has zero latency from `results_i`. It reflects `sel_q` in all states.

## Configuration
- `SERIAL_RESULT_ZERO_FLAG_EN` defined:
  - a zero accumulator is set at start and cleared by any captured 1;
  - `zero_o` = accumulator while `valid_o`=1, else 0.
- Undefined: `zero_o` is tied to 0 and no accumulator logic is built.

## Test plan
- Normal operation (WIDTH=8, NUM_CH=5):
  - Stimulus: start with f_i=3; channel 3 drives 1,0,1,1,0,0,1,0; other channels drive the complement.
  - Required: `valid_o` rises 9 edges after start, `result_o`=8'h4D, `zero_o`=0, `bad_f_o`=0.
- Invalid code:
  - Stimulus: start with f_i=6; channel 0 drives all 0; channel 4 drives all 1.
  - Required: `bad_f_o`=1, `result_o`=8'h00, `zero_o`=1 (macro on) or 0 (macro off).
- Mid-run changes:
  - Stimulus: start with f_i=1; at bit 3, change f_i to 2 and pulse `start_i`.
  - Required: channel 1 is still captured, no restart, valid timing unchanged.
- Hold and back-to-back:
  - Stimulus: DONE held 20 cycles with `start_i` pulsed and no ack; then assert ack and start together with f_i=0.
  - Required: `result_o` is stable and `start_i` is ignored while held. After the ack+start edge, `valid_o`=0 and `busy_o`=1, and the new result is valid 8 edges later.
- Reset mid-run:
  - Stimulus: assert `rst_i` during bit 4.
  - Required: next edge gives IDLE with all outputs 0, and no `valid_o`. A following start with f_i=2 completes normally.
- Ack in IDLE:
  - Stimulus: pulse `ack_i` in IDLE.
  - Required: no state or output change.
